// File: rtl/dmem_pkg.sv
// Shared size codes, FSM state type and size helper for the data-memory sequencer.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  localparam int OP_UNS = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  function automatic logic [3:0] size_bytes(input logic [1:0] sz);
    return 4'd1 << sz;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// One byte-wide bank of the data memory: synchronous write, asynchronous read.
module dmem_bank #(
  parameter int ROWS_AW = 11
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ROWS_AW-1:0] row,
  input  logic [7:0]         wdata,
  output logic [7:0]         rdata
);

  logic [7:0] mem [2**ROWS_AW];

  always_ff @(posedge clk) begin
    if (we) mem[row] <= wdata;
  end

  assign rdata = mem[row];

endmodule

// File: rtl/dmem_seq_ctrl.sv
// Multi-cycle load/store sequencer over LANES byte banks with sign/zero extension.
// DMEM_MISALIGN_SPLIT_EN: run misaligned legal-size accesses byte-serially instead of rejecting them.
module dmem_seq_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int MEM_AW = 11,
  parameter int LANES  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              we,
  input  logic [2:0]        op,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        fsm_state
);

  // Handshake: start is taken only while busy is low; the request then holds busy
  // until the cycle after its single-cycle done pulse (err qualifies done).
  localparam int NBYTES  = DATA_W / 8;
  localparam int KW      = $clog2(NBYTES);
  localparam int DW_AW   = $clog2(DATA_W);
  localparam int ROWS_AW = MEM_AW - $clog2(LANES);

  state_t state, state_n;

  logic              we_q, uns_q, done_q, err_q;
  logic [MEM_AW-1:0] base_q;
  logic [DATA_W-1:0] wdata_q, asm_q, asm_n, ext_n, rdata_q;
  logic [3:0]        nb_q, step_q, beat_q, nbeat_q;
  logic              last_beat, sign_bit;

  logic [3:0] nb_in, step_in, nbeat_in;
  logic       illegal, misal, reject, serial;
  logic       unused_addr;

  assign unused_addr = ^addr[31:MEM_AW];

  always_comb begin
    nb_in   = size_bytes(op[1:0]);
    illegal = (op[1:0] == SZ_D) && (DATA_W == 32);
    misal   = |(addr[2:0] & 3'(nb_in - 4'd1));
`ifdef DMEM_MISALIGN_SPLIT_EN
    reject  = illegal;
    serial  = misal;
`else
    reject  = illegal | misal;
    serial  = 1'b0;
`endif
    step_in = serial ? 4'd1 : 4'(LANES);
    if (serial)                  nbeat_in = nb_in;
    else if (nb_in > 4'(LANES))  nbeat_in = 4'(int'(nb_in) / LANES);
    else                         nbeat_in = 4'd1;
  end

  // Byte k of the request sits at base+k; its bank is the low address bits.
  logic              lane_act  [LANES];
  logic [KW-1:0]     lane_k    [LANES];
  logic [MEM_AW-1:0] lane_addr [LANES];

  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      lane_act[j]  = (state == ST_XFER) && (4'(j) < step_q) &&
                     (int'(beat_q) * int'(step_q) + j < int'(nb_q));
      lane_k[j]    = KW'(int'(beat_q) * int'(step_q) + j);
      lane_addr[j] = base_q + MEM_AW'(int'(beat_q) * int'(step_q) + j);
    end
  end

  logic [LANES-1:0]   bank_we;
  logic [ROWS_AW-1:0] bank_row [LANES];
  logic [7:0]         bank_wd  [LANES];
  logic [7:0]         bank_rd  [LANES];

  always_comb begin
    bank_we = '0;
    for (int b = 0; b < LANES; b++) begin
      bank_row[b] = '0;
      bank_wd[b]  = '0;
    end
    for (int j = 0; j < LANES; j++) begin
      if (lane_act[j]) begin
        bank_we[int'(lane_addr[j]) % LANES]  = we_q;
        bank_row[int'(lane_addr[j]) % LANES] = ROWS_AW'(int'(lane_addr[j]) / LANES);
        bank_wd[int'(lane_addr[j]) % LANES]  = wdata_q[8*int'(lane_k[j]) +: 8];
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_bank
    dmem_bank #(.ROWS_AW(ROWS_AW)) u_bank (
      .clk   (clk),
      .we    (bank_we[g]),
      .row   (bank_row[g]),
      .wdata (bank_wd[g]),
      .rdata (bank_rd[g])
    );
  end

  always_comb begin
    asm_n = asm_q;
    for (int j = 0; j < LANES; j++) begin
      if (lane_act[j] && !we_q)
        asm_n[8*int'(lane_k[j]) +: 8] = bank_rd[int'(lane_addr[j]) % LANES];
    end
  end

  always_comb begin
    sign_bit = !uns_q && asm_n[DW_AW'(8 * int'(nb_q) - 1)];
    ext_n    = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i < 8 * int'(nb_q)) ext_n[i] = asm_n[i];
      else                    ext_n[i] = sign_bit;
    end
  end

  assign last_beat = (beat_q == nbeat_q - 4'd1);

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (start) state_n = reject ? ST_FIN : ST_XFER;
      ST_XFER: if (last_beat) state_n = ST_FIN;
      ST_FIN:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      base_q  <= '0;
      wdata_q <= '0;
      asm_q   <= '0;
      nb_q    <= 4'd1;
      step_q  <= 4'd1;
      beat_q  <= '0;
      nbeat_q <= 4'd1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state  <= state_n;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            we_q    <= we;
            uns_q   <= op[OP_UNS];
            base_q  <= addr[MEM_AW-1:0];
            wdata_q <= wdata;
            nb_q    <= nb_in;
            step_q  <= step_in;
            nbeat_q <= nbeat_in;
            beat_q  <= '0;
            if (reject) begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end
          end
        end
        ST_XFER: begin
          beat_q <= beat_q + 4'd1;
          asm_q  <= asm_n;
          if (last_beat) begin
            done_q <= 1'b1;
            if (!we_q) rdata_q <= ext_n;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != ST_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign fsm_state = state;

endmodule

// File: tb/tb_dmem_seq_ctrl.sv
// Bench for dmem_seq_ctrl: three configurations against a byte-array reference model.
module tb_dmem_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s   [3];
  logic        start_s [3];
  logic        we_s    [3];
  logic [2:0]  op_s    [3];
  logic [31:0] addr_s  [3];
  logic [63:0] wdata_s [3];
  logic        busy_s  [3];
  logic        done_s  [3];
  logic        err_s   [3];
  logic [1:0]  st_s    [3];
  logic [31:0] r0, r1;
  logic [63:0] r2;

  dmem_seq_ctrl #(.DATA_W(32), .MEM_AW(11), .LANES(1)) u0 (
    .clk(clk), .rst(rst_s[0]), .start(start_s[0]), .we(we_s[0]), .op(op_s[0]),
    .addr(addr_s[0]), .wdata(wdata_s[0][31:0]), .busy(busy_s[0]), .done(done_s[0]),
    .err(err_s[0]), .rdata(r0), .fsm_state(st_s[0]));
  dmem_seq_ctrl #(.DATA_W(32), .MEM_AW(11), .LANES(4)) u1 (
    .clk(clk), .rst(rst_s[1]), .start(start_s[1]), .we(we_s[1]), .op(op_s[1]),
    .addr(addr_s[1]), .wdata(wdata_s[1][31:0]), .busy(busy_s[1]), .done(done_s[1]),
    .err(err_s[1]), .rdata(r1), .fsm_state(st_s[1]));
  dmem_seq_ctrl #(.DATA_W(64), .MEM_AW(11), .LANES(2)) u2 (
    .clk(clk), .rst(rst_s[2]), .start(start_s[2]), .we(we_s[2]), .op(op_s[2]),
    .addr(addr_s[2]), .wdata(wdata_s[2]), .busy(busy_s[2]), .done(done_s[2]),
    .err(err_s[2]), .rdata(r2), .fsm_state(st_s[2]));

  // Reference model: per-instance byte memory and last load result.
  int         dw_c    [3] = '{32, 32, 64};
  int         lanes_c [3] = '{1, 4, 2};
  logic [7:0] mem_m   [3][2048];
  logic [63:0] rdata_m [3];

  int errors = 0;
  int checks = 0;
  int cur    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL u%0d %s: got %h expected %h", cur, tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rd_of(input int i);
    case (i)
      0:       return {32'd0, r0};
      1:       return {32'd0, r1};
      default: return r2;
    endcase
  endfunction

  function automatic logic [63:0] ext_m(input logic [63:0] v, input int nb, input logic uns,
                                        input int dw);
    logic [63:0] r, mask;
    mask = (nb >= 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
    r = v & mask;
    if (!uns && nb < 8 && r[8*nb-1]) r = r | ~mask;
    if (dw == 32) r = r & 64'h0000_0000_FFFF_FFFF;
    return r;
  endfunction

  task automatic access(input int i, input logic w, input logic [2:0] o, input logic [31:0] a,
                        input logic [63:0] d, input bit poke);
    int nb, nbeat, exp_cyc, cyc, base;
    logic exp_err, misal, got;
    logic [63:0] v;
    cur     = i;
    nb      = 1 << o[1:0];
    misal   = (a % nb) != 0;
    exp_err = (o[1:0] == 2'b11) && (dw_c[i] == 32);
    nbeat   = nb / lanes_c[i];
    if (nbeat < 1) nbeat = 1;
`ifdef DMEM_MISALIGN_SPLIT_EN
    if (misal) nbeat = nb;
`else
    if (misal) exp_err = 1'b1;
`endif
    exp_cyc = exp_err ? 1 : nbeat + 1;
    base    = int'(a % 2048);
    if (!exp_err) begin
      if (w) begin
        for (int k = 0; k < nb; k++) mem_m[i][(base + k) % 2048] = d[8*k +: 8];
      end else begin
        v = '0;
        for (int k = 0; k < nb; k++) v = v | (64'(mem_m[i][(base + k) % 2048]) << (8 * k));
        rdata_m[i] = ext_m(v, nb, o[2], dw_c[i]);
      end
    end
    @(negedge clk);
    we_s[i] = w; op_s[i] = o; addr_s[i] = a; wdata_s[i] = d; start_s[i] = 1'b1;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      start_s[i] = poke && exp_cyc >= 5 && (cyc == 2 || cyc == 3);
      if (start_s[i]) begin
        we_s[i] = ~w; addr_s[i] = a ^ 32'h4; wdata_s[i] = ~d;
      end
      if (done_s[i]) got = 1'b1;
    end
    start_s[i] = 1'b0;
    check("done_seen", got, 1);
    check("cycles", cyc, exp_cyc);
    check("err", err_s[i], exp_err);
    check("busy_at_done", busy_s[i], 1);
    check("rdata", rd_of(i), rdata_m[i]);
    @(posedge clk);
    #1;
    check("done_pulse", done_s[i], 0);
    check("idle_busy", busy_s[i], 0);
  endtask

  initial begin
    int step;
    logic [31:0] a;
    for (int i = 0; i < 3; i++) begin
      rst_s[i] = 1'b0; start_s[i] = 1'b0; we_s[i] = 1'b0; op_s[i] = '0;
      addr_s[i] = '0; wdata_s[i] = '0; rdata_m[i] = '0;
    end
    #22;
    for (int i = 0; i < 3; i++) rst_s[i] = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      cur = i;
      check("rst_busy", busy_s[i], 0);
      check("rst_done", done_s[i], 0);
      check("rst_err", err_s[i], 0);
      check("rst_rdata", rd_of(i), 0);
    end

    // Give every instance known contents at both ends of its address space.
    for (int i = 0; i < 3; i++) begin
      step = dw_c[i] / 8;
      for (int b = 0; b < 64; b += step) begin
        access(i, 1'b1, (step == 8) ? 3'b011 : 3'b010, 32'(b), {$urandom, $urandom}, 1'b0);
        access(i, 1'b1, (step == 8) ? 3'b011 : 3'b010, 32'h7C0 + 32'(b), {$urandom, $urandom}, 1'b0);
      end
    end

    // Single-lane word round trip and extension cases.
    access(0, 1'b1, 3'b010, 32'h10, 64'h8765_4321, 1'b0);
    access(0, 1'b0, 3'b010, 32'h10, 64'h0, 1'b0);
    check("lw_const", r0, 32'h8765_4321);
    access(0, 1'b0, 3'b000, 32'h13, 64'h0, 1'b0);
    check("lb_const", r0, 32'hFFFF_FF87);
    access(0, 1'b0, 3'b100, 32'h13, 64'h0, 1'b0);
    check("lbu_const", r0, 32'h0000_0087);
    access(0, 1'b0, 3'b001, 32'h12, 64'h0, 1'b0);
    check("lh_const", r0, 32'hFFFF_8765);
    access(0, 1'b0, 3'b010, 32'h11, 64'h0, 1'b0);
    access(0, 1'b1, 3'b010, 32'h13, 64'hDEAD_BEEF, 1'b0);
    access(0, 1'b0, 3'b010, 32'h10, 64'h0, 1'b0);
    access(0, 1'b0, 3'b011, 32'h10, 64'h0, 1'b0);
    access(0, 1'b0, 3'b010, 32'h810, 64'h0, 1'b0);
    access(0, 1'b1, 3'b010, 32'h7FE, 64'h1234_5678, 1'b0);
    access(0, 1'b0, 3'b010, 32'h7FE, 64'h0, 1'b0);
    access(0, 1'b0, 3'b010, 32'h0, 64'h0, 1'b1);

    // Four lanes: half store into the upper lanes of a row.
    access(1, 1'b0, 3'b010, 32'h20, 64'h0, 1'b0);
    access(1, 1'b1, 3'b001, 32'h22, 64'hBEEF, 1'b0);
    access(1, 1'b0, 3'b010, 32'h20, 64'h0, 1'b0);
    check("lanes4_hi", r1[31:16], 16'hBEEF);
    access(1, 1'b0, 3'b000, 32'h21, 64'h0, 1'b0);
    access(1, 1'b0, 3'b110, 32'h23, 64'h0, 1'b0);

    // 64-bit, two lanes: dword at the top of memory and its alias.
    access(2, 1'b1, 3'b011, 32'h7F8, 64'h0123_4567_89AB_CDEF, 1'b0);
    access(2, 1'b0, 3'b011, 32'h7F8, 64'h0, 1'b0);
    check("ld_const", r2, 64'h0123_4567_89AB_CDEF);
    access(2, 1'b0, 3'b011, 32'hFF8, 64'h0, 1'b0);
    access(2, 1'b0, 3'b010, 32'h7F8, 64'h0, 1'b0);
    check("lw64_const", r2, 64'hFFFF_FFFF_89AB_CDEF);
    access(2, 1'b0, 3'b110, 32'h7F8, 64'h0, 1'b0);
    access(2, 1'b0, 3'b011, 32'h7FC, 64'h0, 1'b0);

    // Reset asserted during beat 2 of a single-lane word store.
    cur = 0;
    @(negedge clk);
    we_s[0] = 1'b1; op_s[0] = 3'b010; addr_s[0] = 32'h20; wdata_s[0] = 64'hA1B2_C3D4;
    start_s[0] = 1'b1;
    @(posedge clk); #1; start_s[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_s[0] = 1'b0;
    #1;
    check("abort_busy", busy_s[0], 0);
    check("abort_done", done_s[0], 0);
    check("abort_rdata", rd_of(0), 0);
    mem_m[0][32'h20] = 8'hD4;
    mem_m[0][32'h21] = 8'hC3;
    rdata_m[0] = '0;
    @(negedge clk);
    rst_s[0] = 1'b1;
    access(0, 1'b0, 3'b010, 32'h20, 64'h0, 1'b0);

    // Randomised traffic confined to the initialised regions.
    for (int n = 0; n < 300; n++) begin
      int i;
      i = $urandom_range(0, 2);
      a = ($urandom_range(0, 1) != 0 ? 32'h7C0 : 32'h0) + 32'($urandom_range(0, 55));
      if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_F800);
      access(i, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a,
             {$urandom, $urandom}, $urandom_range(0, 3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
